// File: rtl/btn_onehot_encoder.sv
// Debounced 8-button encoder: reports the index of the highest pressed button once per press.
// Optional MULTI_HOT_ERR_EN adds a multi_hot flag telling the consumer that more than one button was held.
module btn_onehot_encoder #(
   parameter int DEBOUNCE_CYCLES = 4
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [7:0] btn,
   output logic [2:0] code,
   output logic       code_valid,
   input  logic       code_ready
`ifdef MULTI_HOT_ERR_EN
   ,
   output logic       multi_hot
`endif
);

   localparam int               CNT_W    = $clog2(DEBOUNCE_CYCLES);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

   localparam logic [1:0] IDLE    = 2'd0;
   localparam logic [1:0] SETTLE  = 2'd1;
   localparam logic [1:0] VALID   = 2'd2;
   localparam logic [1:0] RELEASE = 2'd3;

   logic [7:0]       btn_m;
   logic [7:0]       btn_s;
   logic [1:0]       state;
   logic [1:0]       state_nxt;
   logic [7:0]       snap;
   logic [7:0]       snap_nxt;
   logic [CNT_W-1:0] cnt;
   logic [CNT_W-1:0] cnt_nxt;
   logic             load_code;

   function automatic logic [2:0] msb_index(input logic [7:0] v);
      logic [2:0] idx;
      idx = 3'd0;
      for (int i = 0; i < 8; i++) begin
         if (v[i]) idx = i[2:0];
      end
      return idx;
   endfunction

   // Two-flop synchronizer; btn_s is the only copy of btn the FSM may look at.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         btn_m <= 8'h00;
         btn_s <= 8'h00;
      end else begin
         btn_m <= btn;
         btn_s <= btn_m;
      end
   end

   // NOTE: every output of this block gets a default first, so no path can leave a value held (no latch).
   always_comb begin
      state_nxt = state;
      snap_nxt  = snap;
      cnt_nxt   = cnt;
      load_code = 1'b0;
      case (state)
         IDLE: begin
            if (btn_s != 8'h00) begin
               snap_nxt  = btn_s;
               cnt_nxt   = CNT_W'(1);
               state_nxt = SETTLE;
            end
         end
         SETTLE: begin
            if (btn_s == 8'h00) begin
               state_nxt = IDLE;
            end else if (btn_s != snap) begin
               snap_nxt = btn_s;
               cnt_nxt  = CNT_W'(1);
            end else if (cnt == CNT_LAST) begin
               load_code = 1'b1;
               state_nxt = VALID;
            end else begin
               cnt_nxt = cnt + CNT_W'(1);
            end
         end
         VALID: begin
            if (code_ready) begin
               cnt_nxt   = '0;
               state_nxt = RELEASE;
            end
         end
         default: begin
            // RELEASE: needs DEBOUNCE_CYCLES zero samples in a row, so a bounce cannot re-fire.
            if (btn_s != 8'h00) begin
               cnt_nxt = '0;
            end else if (cnt == CNT_LAST) begin
               state_nxt = IDLE;
            end else begin
               cnt_nxt = cnt + CNT_W'(1);
            end
         end
      endcase
   end

   // NOTE: state uses non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= IDLE;
         snap  <= 8'h00;
         cnt   <= '0;
      end else begin
         state <= state_nxt;
         snap  <= snap_nxt;
         cnt   <= cnt_nxt;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         code <= 3'd0;
      end else if (load_code) begin
         code <= msb_index(snap);
      end
   end

`ifdef MULTI_HOT_ERR_EN
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         multi_hot <= 1'b0;
      end else if (load_code) begin
         multi_hot <= |(snap & (snap - 8'd1));
      end
   end
`endif

   // Decoded from the state flop only, so it never sees btn or code_ready combinationally.
   assign code_valid = (state == VALID);

endmodule

// File: tb/tb_btn_onehot_encoder.sv
// Directed bench for btn_onehot_encoder: latency, glitch rejection, priority, hold, reset and restart.
// Expected codes are queued when a press is driven and popped by a handshake monitor.
module tb_btn_onehot_encoder;

   logic       clk = 1'b0;
   logic       rst;
   logic [7:0] btn;
   logic [2:0] code;
   logic       code_valid;
   logic       code_ready;
`ifdef MULTI_HOT_ERR_EN
   logic       multi_hot;
`endif

   int         tests  = 0;
   int         fails  = 0;
   int         events = 0;
   logic [2:0] sb[$];

   btn_onehot_encoder #(.DEBOUNCE_CYCLES(4)) dut (
      .clk        (clk),
      .rst        (rst),
      .btn        (btn),
      .code       (code),
      .code_valid (code_valid),
      .code_ready (code_ready)
`ifdef MULTI_HOT_ERR_EN
      ,
      .multi_hot  (multi_hot)
`endif
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [7:0] observed, input logic [7:0] expected);
      tests++;
      assert (observed === expected)
      else begin
         fails++;
         $error("FAIL %s observed=%0h expected=%0h", tag, observed, expected);
      end
   endtask

   // Inputs change and outputs are checked 1 time unit after each rising edge.
   task automatic tick(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic wait_valid(input string tag, input int max_cycles);
      int n;
      n = 0;
      while (code_valid !== 1'b1 && n < max_cycles) begin
         tick(1);
         n++;
      end
      check(tag, 8'(code_valid), 8'd1);
   endtask

   // Handshake monitor: the handshake completes on the next rising edge.
   always @(negedge clk) begin
      if (rst === 1'b0 && code_valid === 1'b1 && code_ready === 1'b1) begin
         events++;
         if (sb.size() == 0) begin
            check("unexpected_event", 8'(code), 8'hFF);
         end else begin
            logic [2:0] exp_code;
            exp_code = sb.pop_front();
            check("event_code", 8'(code), 8'(exp_code));
         end
      end
   end

   initial begin
      rst        = 1'b1;
      btn        = 8'h00;
      code_ready = 1'b0;
      tick(2);
      check("rst_valid", 8'(code_valid), 8'd0);
      check("rst_code", 8'(code), 8'd0);
      rst = 1'b0;
      tick(2);

      // Fixed latency: valid after edge 5, gone the cycle after the handshake.
      btn        = 8'h20;
      code_ready = 1'b1;
      sb.push_back(3'd5);
      for (int k = 0; k < 5; k++) begin
         tick(1);
         check("lat_low", 8'(code_valid), 8'd0);
      end
      tick(1);
      check("lat_high", 8'(code_valid), 8'd1);
      check("lat_code", 8'(code), 8'd5);
`ifdef MULTI_HOT_ERR_EN
      check("lat_single", 8'(multi_hot), 8'd0);
`endif
      tick(1);
      check("lat_fall", 8'(code_valid), 8'd0);
      btn = 8'h00;
      tick(8);

      // Two-sample glitch is rejected.
      btn = 8'h01;
      tick(2);
      btn = 8'h00;
      for (int k = 0; k < 15; k++) begin
         tick(1);
         check("glitch", 8'(code_valid), 8'd0);
      end

      // Multi-bit vector: highest bit wins.
      code_ready = 1'b0;
      btn        = 8'h84;
      wait_valid("prio_wait", 12);
      check("prio_code", 8'(code), 8'd7);
`ifdef MULTI_HOT_ERR_EN
      check("prio_multi", 8'(multi_hot), 8'd1);
`endif
      sb.push_back(3'd7);
      code_ready = 1'b1;
      tick(1);
      check("prio_fall", 8'(code_valid), 8'd0);
      code_ready = 1'b0;
      btn        = 8'h00;
      tick(10);

      // Held without ready: stable for 20 cycles, then exactly one event.
      btn = 8'h08;
      wait_valid("hold_wait", 12);
      for (int k = 0; k < 20; k++) begin
         check("hold_valid", 8'(code_valid), 8'd1);
         check("hold_code", 8'(code), 8'd3);
         tick(1);
      end
      sb.push_back(3'd3);
      code_ready = 1'b1;
      for (int k = 0; k < 10; k++) begin
         tick(1);
         check("hold_once", 8'(code_valid), 8'd0);
      end
      // A release shorter than the debounce window must not re-arm.
      btn = 8'h00;
      tick(2);
      btn = 8'h08;
      for (int k = 0; k < 10; k++) begin
         tick(1);
         check("rel_bounce", 8'(code_valid), 8'd0);
      end
      btn = 8'h00;
      tick(10);
      check("rel_idle", 8'(code_valid), 8'd0);

      // Reset while VALID; held button becomes a fresh press 6 edges later.
      code_ready = 1'b0;
      btn        = 8'h02;
      wait_valid("rst_wait", 12);
      rst = 1'b1;
      #1;
      check("rst_mid_valid", 8'(code_valid), 8'd0);
      check("rst_mid_code", 8'(code), 8'd0);
      tick(1);
      rst = 1'b0;
      for (int k = 1; k <= 5; k++) begin
         tick(1);
         check("rst_lat_low", 8'(code_valid), 8'd0);
      end
      tick(1);
      check("rst_lat_high", 8'(code_valid), 8'd1);
      check("rst_lat_code", 8'(code), 8'd1);
      sb.push_back(3'd1);
      code_ready = 1'b1;
      tick(1);
      check("rst_lat_fall", 8'(code_valid), 8'd0);
      btn = 8'h00;
      tick(10);

      // Vector change mid-SETTLE restarts the count; only code 4 is reported.
      btn = 8'h01;
      sb.push_back(3'd4);
      tick(1);
      check("chg_low0", 8'(code_valid), 8'd0);
      tick(1);
      check("chg_low1", 8'(code_valid), 8'd0);
      btn = 8'h10;
      for (int k = 2; k <= 6; k++) begin
         tick(1);
         check("chg_low", 8'(code_valid), 8'd0);
      end
      tick(1);
      check("chg_high", 8'(code_valid), 8'd1);
      check("chg_code", 8'(code), 8'd4);
      btn = 8'h00;
      tick(12);
      check("chg_idle", 8'(code_valid), 8'd0);

      check("sb_empty", 8'(sb.size()), 8'd0);
      check("event_count", 8'(events), 8'd5);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/btn_onehot_encoder.md
BTN_ONEHOT_ENCODER -- requirements
Module: btn_onehot_encoder

Interface
REQ-001 The block SHALL have parameter DEBOUNCE_CYCLES, default 4, the number of consecutive identical synchronized samples required to accept an input; legal range 2..255.
REQ-002 The block SHALL have port clk, input, 1 bit, system clock; all state updates on the rising edge.
REQ-003 The block SHALL have port rst, input, 1 bit, reset; asynchronous, active-high.
REQ-004 The block SHALL have port btn, input, 8 bits, asynchronous button/switch vector; bit i means "position i pressed".
REQ-005 The block SHALL have port code, output, 3 bits, binary index of the highest set bit of the accepted vector.
REQ-006 The block SHALL have port code_valid, output, 1 bit; high means code holds an accepted, unconsumed event.
REQ-007 The block SHALL have port code_ready, input, 1 bit, consumer acknowledge.
REQ-008 The block SHALL have port multi_hot, output, 1 bit, present only per REQ-025.

Function
REQ-009 btn SHALL pass through a 2-flop synchronizer; btn_s (second flop) SHALL be the only version of btn used by any other logic.
REQ-010 The FSM SHALL have four states: IDLE, SETTLE, VALID, RELEASE; it SHALL hold an 8-bit snapshot register and a counter wide enough for DEBOUNCE_CYCLES.
REQ-011 IDLE: code_valid=0; if btn_s!=0, load snapshot=btn_s, set cnt=1, and go to SETTLE; otherwise remain.
REQ-012 SETTLE, btn_s==0: go to IDLE with no event.
REQ-013 SETTLE, btn_s!=0 and btn_s!=snapshot: load snapshot=btn_s, set cnt=1, and remain in SETTLE.
REQ-014 SETTLE, btn_s==snapshot and cnt==DEBOUNCE_CYCLES-1: load code=index of the highest set bit of snapshot and go to VALID.
REQ-015 SETTLE, btn_s==snapshot and cnt<DEBOUNCE_CYCLES-1: increment cnt.
REQ-016 Latency SHALL be fixed: for btn applied (setup met) before rising edge 0 and held, code_valid SHALL be high after edge DEBOUNCE_CYCLES+1 (edge 5 for default 4).
REQ-017 VALID: code_valid=1; code SHALL be held stable; btn_s changes SHALL be ignored.
REQ-018 VALID with code_ready=1 on an edge: the handshake completes, and the FSM SHALL go to RELEASE with code_valid=0 after that edge; code_ready SHALL be ignored in all other states.
REQ-019 RELEASE: code_valid=0; the FSM SHALL return to IDLE only after DEBOUNCE_CYCLES consecutive samples of btn_s==0; any nonzero sample SHALL restart the count; one press SHALL yield exactly one event.
REQ-020 code SHALL retain its last loaded value outside VALID; it is meaningful only while code_valid=1.
REQ-021 A pulse on btn shorter than DEBOUNCE_CYCLES synchronized samples SHALL produce no event.

Reset
REQ-022 Assertion of rst SHALL immediately clear the synchronizer flops, snapshot, cnt, code=3'b000, code_valid=0, and multi_hot=0, and force state IDLE, including mid-SETTLE or mid-VALID.
REQ-023 After rst deasserts, a button held through reset SHALL be treated as a new press (IDLE→SETTLE path) and produce one event.
REQ-024 No output SHALL depend combinationally on btn or code_ready.

Configuration
REQ-025 With macro MULTI_HOT_ERR_EN defined, port multi_hot SHALL exist and SHALL be registered together with code in REQ-014, equal to 1 if snapshot has more than one bit set, else 0; it is valid only with code_valid.
REQ-026 Without MULTI_HOT_ERR_EN, port multi_hot and its logic SHALL be absent; multi-bit vectors SHALL be encoded by highest-bit priority silently.

Verification
REQ-027 A bench SHALL cover: btn=8'h20 held, code_ready=1 -> code_valid rises after edge 5, code=3'd5, and falls one cycle later.
REQ-028 A bench SHALL cover: btn=8'h01 for 2 cycles, then 0 -> no code_valid assertion.
REQ-029 A bench SHALL cover: btn=8'h84 held, with macro defined -> code=3'd7 and multi_hot=1; without macro -> code=3'd7 and no port.
REQ-030 A bench SHALL cover: btn=8'h08 held, code_ready=0 for 20 cycles -> code_valid high and code=3'd3 stable throughout; after ready, exactly one event until btn=0 is held 4 cycles.
REQ-031 A bench SHALL cover: rst pulsed while in VALID with btn=8'h02 held -> code_valid=0 and code=0 immediately; a new event with code=3'd1 arrives 6 edges after rst release.
REQ-032 A bench SHALL cover: btn changes 8'h01→8'h10 mid-SETTLE -> the count restarts; code=3'd4 is reported once, never 3'd0.
